demux_scan_seq: RTL and testbench
=================================

DEMUX_SCAN_SEQ -- requirements
Module: demux_scan_seq

Interface
REQ-001 Parameter DIR_DOWN, default 0: scan direction; 0 = channel 0 up to channel 15, 1 = channel 15 down to channel 0.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 load_valid  input  1  a 16-bit word is offered for scanning.
REQ-005 load_data  input  16  the word; bit k is the value routed to demux channel k.
REQ-006 load_ready  output  1  the block can accept a word.
REQ-007 step_en  input  1  advance enable; 0 pauses the scan.
REQ-008 dm_in  output  1  serial data to the downstream 1x16 demux "in" port.
REQ-009 dm_sel  output  4  channel select to the downstream demux "sel" port.
REQ-010 dm_valid  output  1  dm_in/dm_sel carry a live bit this cycle.
REQ-011 busy  output  1  a scan is in progress.
REQ-012 done  output  1  one-cycle pulse after the final channel is presented.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-014 In IDLE: load_ready=1, busy=0, dm_valid=0, dm_in=0, dm_sel=0, done=0.
REQ-015 A load is accepted only when load_valid=1 and load_ready=1 at the same rising edge.
REQ-016 On acceptance: load_data goes into a 16-bit shadow register; the channel counter loads 0 (DIR_DOWN=0) or 15 (DIR_DOWN=1); the FSM moves to SCAN.
REQ-017 load_data SHALL be ignored in every state except IDLE; the shadow register is unaffected by input changes during a scan.
REQ-018 In SCAN: load_ready=0, busy=1, dm_sel=counter, dm_valid=step_en, dm_in=step_en AND shadow[counter].
REQ-019 dm_in SHALL be 0 whenever dm_valid=0.
REQ-020 Latency: with step_en held high, the first channel is presented in the cycle after the accept edge.
REQ-021 In SCAN with step_en=1:
- the counter increments (DIR_DOWN=0) or decrements (DIR_DOWN=1) at the edge;
- when the terminal channel (15 up, 0 down) is presented, the FSM moves to DONE instead;
- the counter never wraps.
REQ-022 In SCAN with step_en=0: counter and state hold, and dm_sel keeps showing the held channel.
REQ-023 A full scan SHALL present exactly 16 valid cycles, each channel exactly once and in order.
REQ-024 In DONE: done=1, busy=0, load_ready=0, dm_valid=0; the FSM returns to IDLE unconditionally after one cycle.
REQ-025 A load_valid asserted during DONE is not accepted; it can be accepted at the earliest one cycle later, in IDLE.
REQ-026 Throughput: at best one word per 18 cycles (1 accept + 16 scan + 1 done).
REQ-027 All outputs SHALL be decoded from registered state only, with no combinational path from load_* to any output; the only input-to-output combinational path is step_en to dm_valid/dm_in in SCAN.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL enter IDLE and clear the counter and shadow register to 0.
REQ-029 Reset SHALL take priority over load, step and state transitions, including in the middle of a scan.
REQ-030 From the cycle after the reset edge, all outputs SHALL show their IDLE values (load_ready=1, all others 0).
REQ-031 An aborted scan SHALL NOT produce a done pulse.

Structure
REQ-032 The shared package/include SHALL hold: the constants NUM_CH=16 and SEL_W=4, and the state encodings IDLE/SCAN/DONE, shared with the demux family.
REQ-033 The only natural sub-module is scan_counter: a 4-bit up/down counter with load, enable and terminal-count flag.
REQ-034 The FSM and the output decode SHALL stay in demux_scan_seq.

Verification
REQ-035 Load 16'hA5C3, DIR_DOWN=0, step_en=1 -> dm_sel runs 0..15 on consecutive cycles; dm_in = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done pulses in cycle 17 after accept.
REQ-036 Same word, DIR_DOWN=1 -> dm_sel runs 15..0; dm_in runs 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
REQ-037 step_en low for 3 cycles while channel 5 is presented -> dm_sel holds 5 with dm_valid=0 and dm_in=0; the scan resumes at 5; total valid cycles = 16.
REQ-038 rst asserted while channel 9 is presented -> next cycle is IDLE with load_ready=1 and dm_valid=0; no done pulse.
REQ-039 load_valid held high continuously with 16'hFFFF -> accepts occur 18 cycles apart; load_ready=0 during SCAN and DONE.
REQ-040 Downstream check: connect the block to the 1x16 demux -> across a full scan, demux output bit k shows shadow[k] only in the cycle dm_sel=k.

Source files
------------

// File: rtl/demux_scan_seq_pkg.sv
// Shared constants and state encodings for the demux scan family.
// The FSM states use plain localparams so legacy tools can read them too.
package demux_scan_seq_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] word_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/demux_scan_seq_if.sv
// Load handshake, step control and demux-facing outputs of the scan sequencer.
interface demux_scan_seq_if;
  import demux_scan_seq_pkg::*;

  logic  load_valid;
  word_t load_data;
  logic  load_ready;
  logic  step_en;
  logic  dm_in;
  sel_t  dm_sel;
  logic  dm_valid;
  logic  busy;
  logic  done;

  modport master (
    output load_valid, load_data, step_en,
    input  load_ready, dm_in, dm_sel, dm_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, step_en,
    output load_ready, dm_in, dm_sel, dm_valid, busy, done
  );

endinterface

// File: rtl/demux_scan_seq_scan_counter.sv
// Channel counter: loads the scan start channel, steps up or down when enabled,
// and flags the terminal channel so the sequencer can stop without wrapping.
module demux_scan_seq_scan_counter
  import demux_scan_seq_pkg::*;
#(
  parameter bit Down = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output sel_t cnt_o,
  output logic tc_o
);

  localparam sel_t Start    = Down ? sel_t'(NUM_CH - 1) : sel_t'(0);
  localparam sel_t Terminal = Down ? sel_t'(0) : sel_t'(NUM_CH - 1);

  sel_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Start;
    end else if (en_i) begin
      cnt_d = Down ? cnt_q - sel_t'(1) : cnt_q + sel_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == Terminal);

endmodule

// File: rtl/demux_scan_seq.sv
// Serialises a 16-bit word onto a 1x16 demux, one channel per enabled cycle,
// with an IDLE -> SCAN -> DONE sequence and a one-cycle done pulse.
module demux_scan_seq
  import demux_scan_seq_pkg::*;
#(
  parameter bit DIR_DOWN = 1'b0
) (
  input logic             clk,
  input logic             rst,
  demux_scan_seq_if.slave bus
);

  logic [1:0] state_q, state_d;
  word_t      shadow_q, shadow_d;
  logic       cnt_load, cnt_en, cnt_tc;
  sel_t       cnt;

  demux_scan_seq_scan_counter #(
    .Down (DIR_DOWN)
  ) u_scan_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          state_d  = StScan;
          shadow_d = bus.load_data;
          cnt_load = 1'b1;
        end
      end
      StScan: begin
        // The terminal channel ends the scan instead of stepping, so no wrap.
        if (bus.step_en) begin
          if (cnt_tc) begin
            state_d = StDone;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  // Only step_en reaches the outputs combinationally; the rest is registered state.
  logic in_scan;
  assign in_scan = (state_q == StScan);

  always_comb begin
    bus.load_ready = (state_q == StIdle);
    bus.busy       = in_scan;
    bus.done       = (state_q == StDone);
    bus.dm_valid   = in_scan & bus.step_en;
    bus.dm_in      = in_scan & bus.step_en & shadow_q[cnt];
    bus.dm_sel     = in_scan ? cnt : '0;
  end

endmodule

// File: tb/tb_demux_scan_seq.sv
// Runs an up-scanning and a down-scanning instance side by side against a
// position-based reference model, with directed scans followed by random traffic.
module tb_demux_scan_seq;
  import demux_scan_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_scan_seq_if bus_u ();
  demux_scan_seq_if bus_d ();

  demux_scan_seq #(.DIR_DOWN(1'b0)) u_dut_up (.clk(clk), .rst(rst), .bus(bus_u.slave));
  demux_scan_seq #(.DIR_DOWN(1'b1)) u_dut_dn (.clk(clk), .rst(rst), .bus(bus_d.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: pos = -1 idle, 0..15 = index into scan order, 16 = done cycle.
  int          m_pos[2];
  logic [15:0] m_word[2];

  logic       o_ready[2], o_busy[2], o_valid[2], o_in[2], o_done[2];
  logic [3:0] o_sel[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int chan(input int d, input int pos);
    return (d == 1) ? 15 - pos : pos;
  endfunction

  task automatic check_outs(input int d, input logic st);
    logic [8:0]  exp, got;
    logic [15:0] dmx_exp, dmx_got;
    int          ch;
    dmx_exp = '0;
    if (m_pos[d] < 0) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    end else if (m_pos[d] == 16) begin
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
    end else begin
      ch  = chan(d, m_pos[d]);
      exp = {1'b0, 1'b1, st, st & m_word[d][ch], 4'(ch), 1'b0};
      if (st) dmx_exp = 16'(m_word[d][ch]) << ch;
    end
    got = {o_ready[d], o_busy[d], o_valid[d], o_in[d], o_sel[d], o_done[d]};
    check_eq(d ? "dn_outs" : "up_outs", 32'(got), 32'(exp));
    // Downstream 1x16 demux driven by the observed dm_* outputs.
    dmx_got = o_valid[d] ? (16'(o_in[d]) << o_sel[d]) : 16'h0;
    check_eq(d ? "dn_demux" : "up_demux", 32'(dmx_got), 32'(dmx_exp));
  endtask

  task automatic model_edge(input logic r, input logic lv, input logic [15:0] ld, input logic st);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_pos[d]  = -1;
        m_word[d] = '0;
      end else if (m_pos[d] < 0) begin
        if (lv) begin
          m_word[d] = ld;
          m_pos[d]  = 0;
        end
      end else if (m_pos[d] == 16) begin
        m_pos[d] = -1;
      end else if (st) begin
        m_pos[d] = m_pos[d] + 1;
      end
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic r, input logic lv, input logic [15:0] ld, input logic st);
    rst = r;
    bus_u.load_valid = lv; bus_u.load_data = ld; bus_u.step_en = st;
    bus_d.load_valid = lv; bus_d.load_data = ld; bus_d.step_en = st;
    @(negedge clk);
    o_ready[0] = bus_u.load_ready; o_busy[0] = bus_u.busy; o_valid[0] = bus_u.dm_valid;
    o_in[0]    = bus_u.dm_in;      o_done[0] = bus_u.done; o_sel[0]   = bus_u.dm_sel;
    o_ready[1] = bus_d.load_ready; o_busy[1] = bus_d.busy; o_valid[1] = bus_d.dm_valid;
    o_in[1]    = bus_d.dm_in;      o_done[1] = bus_d.done; o_sel[1]   = bus_d.dm_sel;
    check_outs(0, st);
    check_outs(1, st);
    @(posedge clk);
    model_edge(r, lv, ld, st);
    cyc++;
    #1;
  endtask

  logic [0:15] up_seq, dn_seq;
  int          vcnt, dones, seen_done;
  int          acc_q[$];

  initial begin
    up_seq = 16'b1100001110100101;
    dn_seq = 16'b1010010111000011;
    m_pos  = '{-1, -1};
    m_word = '{16'h0, 16'h0};
    rst = 1'b1;
    bus_u.load_valid = 1'b0; bus_u.load_data = '0; bus_u.step_en = 1'b0;
    bus_d.load_valid = 1'b0; bus_d.load_data = '0; bus_d.step_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a stray step_en that must not matter in IDLE.
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("reset_ready", 32'(o_ready[0]), 32'd1);

    // Fixed word, both directions, step_en held high.
    cycle(1'b0, 1'b1, 16'hA5C3, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b0, 1'b0, 16'(($urandom)), 1'b1);
      if (i <= 16) begin
        check_eq("up_sel", 32'(o_sel[0]), 32'(i - 1));
        check_eq("up_in", 32'(o_in[0]), 32'(up_seq[i-1]));
        check_eq("dn_sel", 32'(o_sel[1]), 32'(16 - i));
        check_eq("dn_in", 32'(o_in[1]), 32'(dn_seq[i-1]));
      end else begin
        check_eq("done_cyc17_up", 32'(o_done[0]), 32'd1);
        check_eq("done_cyc17_dn", 32'(o_done[1]), 32'd1);
      end
    end

    // Pause for three cycles while channel 5 is presented.
    cycle(1'b0, 1'b1, 16'(($urandom)), 1'b1);
    vcnt = 0; seen_done = 0;
    for (int i = 1; i <= 40 && seen_done == 0; i++) begin
      cycle(1'b0, 1'b0, 16'(($urandom)), !(i >= 6 && i <= 8));
      if (i >= 6 && i <= 8) begin
        check_eq("pause_sel", 32'(o_sel[0]), 32'd5);
        check_eq("pause_valid", 32'(o_valid[0]), 32'd0);
        check_eq("pause_in", 32'(o_in[0]), 32'd0);
      end
      vcnt += int'(o_valid[0]);
      if (o_done[0]) seen_done = 1;
    end
    check_eq("pause_valid_total", 32'(vcnt), 32'd16);
    check_eq("pause_done_seen", 32'(seen_done), 32'd1);

    // Reset while channel 9 is presented: back to IDLE, no done pulse.
    cycle(1'b0, 1'b1, 16'(($urandom)), 1'b1);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check_eq("abort_sel9", 32'(o_sel[0]), 32'd9);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      if (i == 0) begin
        check_eq("abort_ready", 32'(o_ready[0]), 32'd1);
        check_eq("abort_valid", 32'(o_valid[0]), 32'd0);
      end
      dones += int'(o_done[0]) + int'(o_done[1]);
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);

    // load_valid held high: accepts every 18 cycles.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
      if (o_ready[0]) acc_q.push_back(cyc);
    end
    check_eq("thru_accepts", 32'(acc_q.size()), 32'd4);
    for (int i = 1; i < acc_q.size(); i++)
      check_eq("thru_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd18);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);

    // Random traffic with occasional mid-scan resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0), 16'(($urandom)),
            ($urandom_range(3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
